// File: rtl/um_pkt_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : um_pkt_arb                                                     |
// | Brief    : Two-input packet arbiter. Each input is buffered in its own    |
// |            FIFO and whole packets are forwarded round-robin into the      |
// |            single pktin interface of the um user module.                  |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+

module um_pkt_arb #(
    parameter int FIFO_AW       = 8,
    parameter int MAX_PKT_WORDS = 96
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         in0_data_wr,
    input  logic [133:0] in0_data,
    input  logic         in0_data_valid,
    input  logic         in0_data_valid_wr,
    output logic         in0_ready,

    input  logic         in1_data_wr,
    input  logic [133:0] in1_data,
    input  logic         in1_data_valid,
    input  logic         in1_data_valid_wr,
    output logic         in1_ready,

    output logic         pktout_data_wr,
    output logic [133:0] pktout_data,
    output logic         pktout_data_valid,
    output logic         pktout_data_valid_wr,
    input  logic         pktout_ready
);

    localparam int               c_DEPTH_N  = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_DEPTH    = (FIFO_AW+1)'(c_DEPTH_N);
    localparam logic [FIFO_AW:0] c_MAX_PKT  = (FIFO_AW+1)'(MAX_PKT_WORDS);
    localparam logic [FIFO_AW:0] c_ONE      = (FIFO_AW+1)'(1);
    localparam logic [1:0]       c_TAG_TAIL = 2'b10;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    // Both inputs gathered into vectors so one generate body serves both FIFOs
    logic [1:0]        w_in_wr;
    logic [1:0]        w_in_valid;
    logic [1:0]        w_in_vwr;
    logic [1:0][133:0] w_in_data;
    logic [1:0][134:0] w_rd_word;
    logic [1:0]        w_pop;
    logic [1:0]        w_pkt_avail;
    logic [1:0]        w_in_ready;

    assign w_in_wr    = {in1_data_wr, in0_data_wr};
    assign w_in_valid = {in1_data_valid, in0_data_valid};
    assign w_in_vwr   = {in1_data_valid_wr, in0_data_valid_wr};
    assign w_in_data  = {in1_data, in0_data};
    assign in0_ready  = w_in_ready[0];
    assign in1_ready  = w_in_ready[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [134:0]     r_mem [c_DEPTH_N];
        logic [FIFO_AW:0] r_wr_ptr;
        logic [FIFO_AW:0] r_rd_ptr;
        logic [FIFO_AW:0] r_pkt_cnt;
        logic [FIFO_AW:0] w_used;
        logic             r_ready;
        logic             w_in_tail;
        logic             w_push;
        logic             w_push_tail;
        logic             w_pop_tail;

        // Pointers carry one extra bit so full and empty are distinguishable
        assign w_used          = r_wr_ptr - r_rd_ptr;
        assign w_in_tail       = (w_in_data[gi][133:132] == c_TAG_TAIL);
        // A write into a full FIFO is a source violation and is simply dropped
        assign w_push          = w_in_wr[gi] && (w_used != c_DEPTH);
        assign w_push_tail     = w_push && w_in_tail;
        assign w_rd_word[gi]   = r_mem[r_rd_ptr[FIFO_AW-1:0]];
        assign w_pop_tail      = w_pop[gi] && (w_rd_word[gi][133:132] == c_TAG_TAIL);
        assign w_pkt_avail[gi] = (r_pkt_cnt != '0);
        assign w_in_ready[gi]  = r_ready;

        // Word storage; bit 134 holds the keep flag, only ever set on a tail
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr[FIFO_AW-1:0]] <=
                    {w_in_tail && w_in_vwr[gi] && w_in_valid[gi], w_in_data[gi]};
            end
        end

        // Pointers, complete-packet count and the registered input-ready flag
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_pkt_cnt <= '0;
                r_ready   <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ONE;
                end
                if (w_pop[gi]) begin
                    r_rd_ptr <= r_rd_ptr + c_ONE;
                end
                case ({w_push_tail, w_pop_tail})
                    2'b10:   r_pkt_cnt <= r_pkt_cnt + c_ONE;
                    2'b01:   r_pkt_cnt <= r_pkt_cnt - c_ONE;
                    default: r_pkt_cnt <= r_pkt_cnt;
                endcase
                r_ready <= ((c_DEPTH - w_used) >= c_MAX_PKT);
            end
        end
    end

    logic [0:0]   r_state;
    logic         r_grant;
    logic         r_last_grant;
    logic         r_out_wr;
    logic [133:0] r_out_data;
    logic         r_out_valid;
    logic         r_out_vwr;

    logic         w_grant_sel;
    logic         w_grant_fire;
    logic         w_sel;
    logic         w_read_en;
    logic [134:0] w_word;
    logic         w_rd_tail;

    // Round-robin pick among inputs holding at least one complete packet
    always_comb begin
        w_grant_sel = 1'b0;
        if (w_pkt_avail == 2'b11) begin
            w_grant_sel = ~r_last_grant;
        end else begin
            w_grant_sel = w_pkt_avail[1];
        end
    end

    // Holding off while the previous tail is still on the output inserts the
    // single idle cycle between packets; the head is read on the grant edge so
    // it lands on pktout in the very next cycle.
    assign w_grant_fire = (r_state == c_ST_IDLE) && pktout_ready &&
                          (w_pkt_avail != 2'b00) && !r_out_wr;
    assign w_sel        = (r_state == c_ST_SEND) ? r_grant : w_grant_sel;
    assign w_read_en    = (r_state == c_ST_SEND) || w_grant_fire;
    assign w_pop        = {w_read_en && w_sel, w_read_en && !w_sel};
    assign w_word       = w_rd_word[w_sel];
    assign w_rd_tail    = (w_word[133:132] == c_TAG_TAIL);

    // Grant state machine with registered pktout outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_out_wr     <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_vwr    <= 1'b0;
        end else begin
            r_out_wr    <= w_read_en;
            r_out_vwr   <= w_read_en && w_rd_tail;
            r_out_valid <= w_read_en && w_rd_tail && w_word[134];
            if (w_read_en) begin
                r_out_data <= w_word[133:0];
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_fire) begin
                        r_grant      <= w_grant_sel;
                        r_last_grant <= w_grant_sel;
                        if (!w_rd_tail) begin
                            r_state <= c_ST_SEND;
                        end
                    end
                end
                c_ST_SEND: begin
                    if (w_rd_tail) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign pktout_data_wr       = r_out_wr;
    assign pktout_data          = r_out_data;
    assign pktout_data_valid    = r_out_valid;
    assign pktout_data_valid_wr = r_out_vwr;

endmodule

`default_nettype wire

// File: tb/tb_um_pkt_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_um_pkt_arb                                                  |
// | Brief    : Self-checking bench for um_pkt_arb: vector table of single     |
// |            packets plus sequences for arbitration, backpressure, ready    |
// |            threshold and reset; output words checked via a scoreboard.    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+

module tb_um_pkt_arb;

    localparam int AW   = 8;
    localparam int MAXW = 96;

    typedef struct packed {
        logic [133:0] data;
        logic         vwr;
        logic         valid;
    } exp_t;

    typedef struct {
        int   port;
        int   nw;
        logic vflag;
        logic vwr;
        logic exp_valid;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in0_data_wr, in0_data_valid, in0_data_valid_wr, in0_ready;
    logic [133:0] in0_data;
    logic         in1_data_wr, in1_data_valid, in1_data_valid_wr, in1_ready;
    logic [133:0] in1_data;
    logic         pktout_data_wr, pktout_data_valid, pktout_data_valid_wr;
    logic [133:0] pktout_data;
    logic         pktout_ready;

    int           n_checks  = 0;
    int           n_fail    = 0;
    int           cyc       = 0;
    int           out_words = 0;
    int           head_cycs[$];
    int           tail_cycs[$];
    exp_t         sb_q[$];
    logic [133:0] pkt_words [2][256];

    um_pkt_arb #(
        .FIFO_AW       (AW),
        .MAX_PKT_WORDS (MAXW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in0_data_wr          (in0_data_wr),
        .in0_data             (in0_data),
        .in0_data_valid       (in0_data_valid),
        .in0_data_valid_wr    (in0_data_valid_wr),
        .in0_ready            (in0_ready),
        .in1_data_wr          (in1_data_wr),
        .in1_data             (in1_data),
        .in1_data_valid       (in1_data_valid),
        .in1_data_valid_wr    (in1_data_valid_wr),
        .in1_ready            (in1_ready),
        .pktout_data_wr       (pktout_data_wr),
        .pktout_data          (pktout_data),
        .pktout_data_valid    (pktout_data_valid),
        .pktout_data_valid_wr (pktout_data_valid_wr),
        .pktout_ready         (pktout_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: every forwarded word is matched against the scoreboard
    always @(negedge clk) begin : p_mon
        exp_t e;
        if (rst_n === 1'b1 && pktout_data_wr === 1'b1) begin
            out_words++;
            if (pktout_data[133:132] == 2'b01) head_cycs.push_back(cyc);
            if (pktout_data[133:132] == 2'b10) tail_cycs.push_back(cyc);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %h, expected no output", pktout_data);
            end else begin
                e = sb_q.pop_front();
                check("out_data", pktout_data, e.data);
                check("out_valid_wr", pktout_data_valid_wr, e.vwr);
                check("out_valid", pktout_data_valid, e.valid);
            end
        end
    end

    // Create a packet for a port and queue the words expected at the output
    task automatic build_pkt(input int port, input int nw, input logic exp_valid);
        logic [1:0]   tag;
        logic [133:0] w;
        exp_t         e;
        for (int i = 0; i < nw; i++) begin
            tag = (i == 0) ? 2'b01 : ((i == nw - 1) ? 2'b10 : 2'b11);
            w   = {tag, $urandom(), $urandom(), $urandom(), $urandom(), 4'(i)};
            pkt_words[port][i] = w;
            e.data  = w;
            e.vwr   = (i == nw - 1);
            e.valid = (i == nw - 1) ? exp_valid : 1'b0;
            sb_q.push_back(e);
        end
    endtask

    task automatic drive_pkt(input int port, input int nw, input logic vflag,
                             input logic vwr, output int tail_cyc);
        tail_cyc = -1;
        for (int i = 0; i < nw; i++) begin
            @(posedge clk); #1;
            if (port == 0) begin
                in0_data_wr       = 1'b1;
                in0_data          = pkt_words[0][i];
                in0_data_valid    = vflag;
                in0_data_valid_wr = (i == nw - 1) ? vwr : 1'b0;
            end else begin
                in1_data_wr       = 1'b1;
                in1_data          = pkt_words[1][i];
                in1_data_valid    = vflag;
                in1_data_valid_wr = (i == nw - 1) ? vwr : 1'b0;
            end
            if (i == nw - 1) tail_cyc = cyc;
        end
        @(posedge clk); #1;
        if (port == 0) begin
            in0_data_wr = 1'b0; in0_data_valid = 1'b0; in0_data_valid_wr = 1'b0;
        end else begin
            in1_data_wr = 1'b0; in1_data_valid = 1'b0; in1_data_valid_wr = 1'b0;
        end
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        check_int("drain_done", sb_q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    initial begin : p_main
        vec_t tv [6];
        int   t, t0, t1, u, v, base;

        // port, words, valid flag, valid strobe, expected forwarded keep flag
        tv[0] = '{0, 5, 1'b1, 1'b1, 1'b1};
        tv[1] = '{1, 3, 1'b0, 1'b1, 1'b0};
        tv[2] = '{0, 2, 1'b1, 1'b0, 1'b0};
        tv[3] = '{1, 4, 1'b1, 1'b1, 1'b1};
        tv[4] = '{0, 7, 1'b0, 1'b1, 1'b0};
        tv[5] = '{1, 6, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; pktout_ready = 1'b1;
        in0_data_wr = 1'b0; in0_data = '0; in0_data_valid = 1'b0; in0_data_valid_wr = 1'b0;
        in1_data_wr = 1'b0; in1_data = '0; in1_data_valid = 1'b0; in1_data_valid_wr = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_wr", pktout_data_wr, 0);
        check("rst_out_data", pktout_data, 0);
        check("rst_out_valid", pktout_data_valid, 0);
        check("rst_out_valid_wr", pktout_data_valid_wr, 0);
        check("rst_in0_ready", in0_ready, 0);
        check("rst_in1_ready", in1_ready, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("ready_first_cycle", in0_ready, 0);
        @(negedge clk);
        check("in0_ready_rise", in0_ready, 1);
        check("in1_ready_rise", in1_ready, 1);

        // Single packets: latency, contiguity, keep flag
        for (int k = 0; k < 6; k++) begin
            head_cycs.delete(); tail_cycs.delete();
            build_pkt(tv[k].port, tv[k].nw, tv[k].exp_valid);
            drive_pkt(tv[k].port, tv[k].nw, tv[k].vflag, tv[k].vwr, t);
            drain(200);
            check_int("vec_head_latency", (head_cycs.size() > 0) ? head_cycs[0] : -1, t + 2);
            check_int("vec_tail_cycle", (tail_cycs.size() > 0) ? tail_cycs[0] : -1, t + 1 + tv[k].nw);
        end

        // Round-robin with both inputs loaded in the same cycle, twice
        for (int r = 0; r < 2; r++) begin
            head_cycs.delete();
            build_pkt(0, 3, 1'b1);
            build_pkt(1, 3, 1'b1);
            fork
                drive_pkt(0, 3, 1'b1, 1'b1, t0);
                drive_pkt(1, 3, 1'b1, 1'b1, t1);
            join
            drain(100);
            check_int("rr_head0", (head_cycs.size() > 0) ? head_cycs[0] : -1, t0 + 2);
            check_int("rr_head1", (head_cycs.size() > 1) ? head_cycs[1] : -1, t0 + 6);
        end

        // Backpressure: hold, release, drop mid-packet, release again
        @(posedge clk); #1; pktout_ready = 1'b0;
        build_pkt(0, 6, 1'b1); drive_pkt(0, 6, 1'b1, 1'b1, t);
        build_pkt(1, 6, 1'b1); drive_pkt(1, 6, 1'b1, 1'b1, t);
        base = out_words; head_cycs.delete();
        repeat (5) @(posedge clk);
        check_int("bp_hold_no_output", out_words - base, 0);
        @(posedge clk); #1; pktout_ready = 1'b1; u = cyc;
        repeat (3) @(posedge clk); #1; pktout_ready = 1'b0;
        repeat (9) @(posedge clk); #1; pktout_ready = 1'b1; v = cyc;
        drain(100);
        check_int("bp_head0", (head_cycs.size() > 0) ? head_cycs[0] : -1, u + 1);
        check_int("bp_head1", (head_cycs.size() > 1) ? head_cycs[1] : -1, v + 1);

        // Ready threshold: 161 words buffered with output blocked
        @(posedge clk); #1; pktout_ready = 1'b0;
        base = out_words;
        build_pkt(0, 80, 1'b1); drive_pkt(0, 80, 1'b1, 1'b1, t);
        build_pkt(0, 81, 1'b1); drive_pkt(0, 81, 1'b1, 1'b1, t);
        @(negedge clk);
        check("thr_ready_free96", in0_ready, 1);
        @(negedge clk);
        check("thr_ready_free95", in0_ready, 0);
        check("thr_in1_ready", in1_ready, 1);
        check_int("thr_blocked", out_words - base, 0);
        head_cycs.delete();
        @(posedge clk); #1; pktout_ready = 1'b1; u = cyc;
        @(negedge clk);
        check("thr_ready_grant_cycle", in0_ready, 0);
        @(negedge clk);
        check("thr_ready_lag", in0_ready, 0);
        @(negedge clk);
        check("thr_ready_back", in0_ready, 1);
        drain(400);
        check_int("thr_head", (head_cycs.size() > 0) ? head_cycs[0] : -1, u + 1);

        // Reset in the middle of an outgoing packet
        build_pkt(0, 20, 1'b1); drive_pkt(0, 20, 1'b1, 1'b1, t);
        repeat (4) @(posedge clk); #1; rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("mrst_out_wr", pktout_data_wr, 0);
        check("mrst_out_data", pktout_data, 0);
        check("mrst_out_valid", pktout_data_valid, 0);
        check("mrst_out_valid_wr", pktout_data_valid_wr, 0);
        check("mrst_in0_ready", in0_ready, 0);
        check("mrst_in1_ready", in1_ready, 0);
        @(negedge clk);
        check("mrst_in0_ready_rise", in0_ready, 1);
        base = out_words;
        repeat (10) @(posedge clk);
        check_int("mrst_flushed", out_words - base, 0);
        head_cycs.delete();
        build_pkt(0, 3, 1'b1);
        build_pkt(1, 3, 1'b0);
        fork
            drive_pkt(0, 3, 1'b1, 1'b1, t0);
            drive_pkt(1, 3, 1'b0, 1'b1, t1);
        join
        drain(100);
        check_int("mrst_head0", (head_cycs.size() > 0) ? head_cycs[0] : -1, t0 + 2);
        check_int("mrst_head1", (head_cycs.size() > 1) ? head_cycs[1] : -1, t0 + 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : p_timeout
        #400000;
        $display("FAIL global_timeout: got still running, expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

`default_nettype wire
